// File: rtl/button_arbiter_pkg.sv
// Shared sizing constants and FSM encoding for the button press arbiter.
package button_arbiter_pkg;

  localparam int NUM_BUTTONS = 4;
  localparam int IDX_BITS    = 2;
  localparam int DROP_BITS   = 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/button_arbiter_if.sv
// Press/event bundle between the debouncer side, the arbiter and the event consumer.
interface button_arbiter_if #(
  parameter int NUM_BUTTONS = button_arbiter_pkg::NUM_BUTTONS,
  parameter int IDX_BITS    = button_arbiter_pkg::IDX_BITS,
  parameter int DROP_BITS   = button_arbiter_pkg::DROP_BITS
);

  logic [NUM_BUTTONS-1:0] rise;
  logic                   evt_ready;
  logic                   evt_valid;
  logic [IDX_BITS-1:0]    evt_id;
  logic [NUM_BUTTONS-1:0] pending;
  logic                   overflow;
  logic [DROP_BITS-1:0]   drop_count;

  modport master (
    output rise, evt_ready,
    input  evt_valid, evt_id, pending, overflow, drop_count
  );

  modport slave (
    input  rise, evt_ready,
    output evt_valid, evt_id, pending, overflow, drop_count
  );

endinterface

// File: rtl/button_arbiter_rr_pick.sv
// Round-robin search: first set request starting one past the last grant, wrapping.
module rr_pick #(
  parameter int NUM_BUTTONS = button_arbiter_pkg::NUM_BUTTONS,
  parameter int IDX_BITS    = button_arbiter_pkg::IDX_BITS
) (
  input  logic [NUM_BUTTONS-1:0] req_i,
  input  logic [IDX_BITS-1:0]    last_grant_i,
  output logic                   found_o,
  output logic [IDX_BITS-1:0]    idx_o
);

  logic [IDX_BITS-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_BUTTONS; k++) begin
      cand = IDX_BITS'((int'(last_grant_i) + k) % NUM_BUTTONS);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/button_arbiter.sv
// Collects button presses into a pending set and offers them one at a time, round-robin,
// over a valid/ready handshake; a press landing on an already-pending button is dropped and counted.
module button_arbiter #(
  parameter int NUM_BUTTONS = button_arbiter_pkg::NUM_BUTTONS,
  parameter int IDX_BITS    = button_arbiter_pkg::IDX_BITS,
  parameter int DROP_BITS   = button_arbiter_pkg::DROP_BITS
) (
  input  logic            clock,
  input  logic            reset,
  button_arbiter_if.slave bus
);

  import button_arbiter_pkg::*;

  arb_state_e             state_q;
  logic [IDX_BITS-1:0]    evt_id_q;
  logic [IDX_BITS-1:0]    last_grant_q;
  logic [NUM_BUTTONS-1:0] pending_q, pending_d;
  logic                   overflow_q, overflow_d;
  logic [DROP_BITS-1:0]   drop_count_q, drop_count_d;

  logic                   found;
  logic [IDX_BITS-1:0]    win;
  logic                   load;
  logic [NUM_BUTTONS-1:0] clr;
  logic [NUM_BUTTONS-1:0] dropped;

  rr_pick #(
    .NUM_BUTTONS (NUM_BUTTONS),
    .IDX_BITS    (IDX_BITS)
  ) u_pick (
    .req_i        (pending_q),
    .last_grant_i (last_grant_q),
    .found_o      (found),
    .idx_o        (win)
  );

  // A new winner is taken whenever the output slot is empty or being consumed.
  assign load = found && ((state_q == S_IDLE) || bus.evt_ready);
  assign clr  = load ? (NUM_BUTTONS'(1) << win) : '0;

  // Set beats clear, so only presses on bits that stay pending count as drops.
  assign dropped      = bus.rise & pending_q & ~clr;
  assign pending_d    = (pending_q & ~clr) | bus.rise;
  assign overflow_d   = |dropped;
  assign drop_count_d = (overflow_d && (drop_count_q != '1)) ? drop_count_q + DROP_BITS'(1)
                                                             : drop_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      evt_id_q     <= '0;
      last_grant_q <= IDX_BITS'(NUM_BUTTONS - 1);
      pending_q    <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            state_q      <= S_OFFER;
            evt_id_q     <= win;
            last_grant_q <= win;
          end
        end
        S_OFFER: begin
          if (bus.evt_ready) begin
            if (found) begin
              evt_id_q     <= win;
              last_grant_q <= win;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.evt_valid  = (state_q == S_OFFER);
  assign bus.evt_id     = evt_id_q;
  assign bus.pending    = pending_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_count_q;

endmodule
